// File: rtl/ex_div_unit.sv
// Iterative 32-bit signed/unsigned restoring divider for the EX stage (DIV/DIVU).
// Result is {remainder, quotient}; stallreq_o freezes the pipeline while busy.
//
// state  | meaning
// IDLE   | waiting for start_i; operands sampled here
// BYZERO | divisor was zero; load the fixed divide-by-zero result
// ON     | one shift-subtract step per cycle, 32 steps
// END    | result valid; held until start_i drops
module ex_div_unit #(
  parameter int ITER_CNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [64:0] work_q;
  logic [31:0] dsor_q;
  logic        qneg_q, rneg_q;
  logic [63:0] res_q;

  logic [31:0] abs1, abs2;
  logic [64:0] shifted, step_w;
  logic [32:0] upper;
  logic [31:0] q_fix, r_fix;
  logic        last_step;

  assign abs1 = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

  // Restoring step: the remainder never exceeds the divisor, so bit 64 is
  // always clear before the shift and the left shift loses nothing.
  assign shifted = work_q << 1;
  assign upper   = shifted[64:32];
  assign step_w  = (upper >= {1'b0, dsor_q})
                   ? {upper - {1'b0, dsor_q}, shifted[31:1], 1'b1}
                   : shifted;

  assign q_fix     = qneg_q ? -step_w[31:0]  : step_w[31:0];
  assign r_fix     = rneg_q ? -step_w[63:32] : step_w[63:32];
  assign last_step = (cnt_q == 6'(ITER_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = (opdata2_i == 32'd0) ? BYZERO : ON;
        BYZERO:  state_d = END;
        ON:      if (last_step) state_d = END;
        END:     if (!start_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 6'd0;
      work_q <= 65'd0;
      dsor_q <= 32'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= 64'd0;
    end else if (annul_i) begin
      cnt_q <= 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q  <= 6'd0;
            dsor_q <= abs2;
            qneg_q <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            rneg_q <= signed_i & opdata1_i[31];
            // divide-by-zero keeps the dividend exactly as given
            work_q <= {33'd0, (opdata2_i == 32'd0) ? opdata1_i : abs1};
          end
        end
        BYZERO: res_q <= {work_q[31:0], 32'hFFFF_FFFF};
        ON: begin
          work_q <= step_w;
          cnt_q  <= cnt_q + 6'd1;
          if (last_step) res_q <= {r_fix, q_fix};
        end
        default: ;
      endcase
    end
  end

  assign ready_o    = (state_q == END);
  assign result_o   = ready_o ? res_q : 64'd0;
  assign stallreq_o = !annul_i &&
                      (((state_q == IDLE) && start_i) || (state_q == BYZERO) || (state_q == ON));

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_assert = 0;
  int n_fail   = 0;

  ex_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: divide magnitudes, then apply the sign rules.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    ma = (sgn && a[31]) ? 32'd0 - a : a;
    mb = (sgn && b[31]) ? 32'd0 - b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] != b[31])) q = 32'd0 - q;
    if (sgn && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Called on a negedge with the block idle; returns on a negedge, idle again.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input string tag);
    int lat;
    int stalls;
    int exp_lat;
    exp_lat   = (b == 32'd0) ? 2 : 33;
    start_i   = 1'b1;
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = sgn;
    lat       = 0;
    stalls    = 0;
    #1;
    while (ready_o !== 1'b1 && lat < 100) begin
      if (stallreq_o === 1'b1) stalls++;
      @(negedge clk);
      if (lat == 0) begin
        opdata1_i = ~a;
        opdata2_i = b ^ 32'h5;
        signed_i  = ~sgn;
      end
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_lat));
    chk({tag, "_stall_at_ready"}, 64'(stallreq_o), 64'd0);
    chk({tag, "_result"}, result_o, exp);
    @(negedge clk);
    chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
    chk({tag, "_hold_result"}, result_o, exp);
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_idle_result"}, result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    annul_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(32'd7, 32'd2, 1'b0, {32'h1, 32'h3}, "udiv_7_2");
    do_div(32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "sdiv_m7_2");
    do_div(32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, "udiv_max_16");
    do_div(32'hFFFF_FFFF, 32'h10, 1'b1, {32'hFFFF_FFFF, 32'h0}, "sdiv_m1_16");
    do_div(32'h1234, 32'h0, 1'b0, {32'h1234, 32'hFFFF_FFFF}, "div_by_zero");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, "sdiv_overflow");

    // annul in the middle of the iteration
    start_i   = 1'b1;
    opdata1_i = 32'h1234_5678;
    opdata2_i = 32'd3;
    signed_i  = 1'b0;
    repeat (11) @(negedge clk);
    chk("annul_busy_before", 64'(stallreq_o), 64'd1);
    annul_i = 1'b1;
    #1;
    chk("annul_stall_forced_low", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("annul_back_to_idle", 64'(stallreq_o), 64'd0);
    chk("annul_ready_low", 64'(ready_o), 64'd0);
    @(negedge clk);
    do_div(32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, "after_annul_100_7");

    // synchronous reset in the middle of the iteration
    start_i   = 1'b1;
    opdata1_i = 32'hDEAD_BEEF;
    opdata2_i = 32'd9;
    signed_i  = 1'b1;
    repeat (6) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    chk("rst_mid_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_stays_idle", 64'(stallreq_o), 64'd0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = $urandom;
        default: rb = 32'd0 - 32'($urandom_range(1, 15));
      endcase
      if (i % 6 == 5) ra = 32'h8000_0000;
      do_div(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
